// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive buffer.
package uart_pkg;

    // Number of bit-times in one character on the line (start, 8 data, parity, stop).
    localparam int CHAR_BITS = 11;

    // One FIFO entry: receiver error flag above the received byte.
    typedef struct packed {
        logic       error;
        logic [7:0] data;
    } rx_entry_t;

    // Capture stage phases.
    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_CAPT   = 2'd1,
        CAP_COMMIT = 2'd2
    } cap_state_e;

    // Clock cycles spanned by one character at the given line rate.
    function automatic int char_cycles(input int clk_rate, input int baud_rate);
        return (clk_rate / baud_rate) * CHAR_BITS;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on pop_data (zero when empty); a push into a full FIFO is accepted only when
// a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Head entry falls through to the read port; forced to zero while empty.
    assign pop_data = empty ? '0 : mem_q[head_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_ok) begin
            head_d = head_q + AW'(1);
        end
        if (push_ok) begin
            tail_d = tail_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // One-hot write select per storage slot.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_ok && (tail_q == AW'(gi));
        end
    endgenerate

    // Storage needs no reset: stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_q[i] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind the UART receiver core: captures each byte with
// its error flag into a FWFT FIFO and keeps overflow, error-count, timeout
// and interrupt status for the register bus.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int THRESHOLD     = 4,
    parameter int CLK_RATE      = 100000000,
    parameter int BAUD_RATE     = 19200,
    parameter int TIMEOUT_CHARS = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_strobe,
    input  logic          rx_error,
    input  logic          rd_en,
    input  logic          clr_status,
    output logic [8:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [7:0]    err_count,
    output logic          irq
);

    localparam logic [31:0] TMO_LIMIT =
        32'(TIMEOUT_CHARS * char_cycles(CLK_RATE, BAUD_RATE));

    cap_state_e state_q, state_d;
    cap_state_e phase;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic       commit;
    rx_entry_t  entry;

    logic       push_ok, pop_ok;
    logic [8:0] fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic       fifo_full, fifo_empty;

    logic        ovf_event, err_event;
    logic        overflow_q, overflow_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_flag_q, tmo_flag_d;
    logic        irq_q, irq_d;

    // Capture FSM state register. Only IDLE and COMMIT are ever held across an
    // edge: the CAPT phase is the strobe cycle itself, and the byte commits the
    // very next cycle because that is when rx_error becomes valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CAP_IDLE;
            pend_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    // Capture FSM next state: a strobe while committing restarts the capture.
    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        pend_byte_d = rx_strobe ? rx_data : pend_byte_q;
        phase       = state_q;
        if (state_q == CAP_IDLE && rx_strobe) begin
            phase = CAP_CAPT;
        end
        case (phase)
            CAP_CAPT: begin
                state_d = CAP_COMMIT;
            end
            CAP_COMMIT: begin
                commit  = 1'b1;
                state_d = rx_strobe ? CAP_COMMIT : CAP_IDLE;
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase
    end

    assign entry.error = rx_error;
    assign entry.data  = pend_byte_q;

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (commit),
        .push_data (entry),
        .pop       (rd_en),
        .pop_data  (fifo_rd_data),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky status, idle timeout and interrupt next-state. A new event in the
    // same cycle as clr_status takes priority over the clear.
    always_comb begin
        ovf_event   = commit && !push_ok;
        err_event   = commit && rx_error;
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_flag_d  = tmo_flag_q;

        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clr_status) begin
            overflow_d = 1'b0;
        end

        if (clr_status) begin
            err_count_d = err_event ? 8'd1 : 8'd0;
        end else if (err_event && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end

        if (fifo_empty || commit || pop_ok) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_LIMIT) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end

        if (commit || pop_ok) begin
            tmo_flag_d = 1'b0;
        end else if (!fifo_empty && tmo_cnt_d == TMO_LIMIT) begin
            tmo_flag_d = 1'b1;
        end

        irq_d = (fifo_count >= CW'(THRESHOLD)) | tmo_flag_q | overflow_q;
    end

    // Status, timeout and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            err_count_q <= '0;
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_flag_q  <= tmo_flag_d;
            irq_q       <= irq_d;
        end
    end

    assign rd_data   = fifo_rd_data;
    assign empty     = fifo_empty;
    assign full      = fifo_full;
    assign count     = fifo_count;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed testbench for uart_rx_buffer with a fast line rate so the idle
// timeout fits in a short run.
module tb_uart_rx_buffer;

    localparam int DEPTH         = 8;
    localparam int THRESHOLD     = 4;
    localparam int CLK_RATE      = 1000000;
    localparam int BAUD_RATE     = 100000;
    localparam int TIMEOUT_CHARS = 4;
    // 4 chars * (1e6 / 1e5) * 11 cycles
    localparam int TMO_CYCLES    = 440;
    localparam int CW            = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic          rx_error;
    logic          rd_en;
    logic          clr_status;
    logic [8:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    err_count;
    logic          irq;

    int n_vec  = 0;
    int n_miss = 0;

    uart_rx_buffer #(
        .DEPTH         (DEPTH),
        .THRESHOLD     (THRESHOLD),
        .CLK_RATE      (CLK_RATE),
        .BAUD_RATE     (BAUD_RATE),
        .TIMEOUT_CHARS (TIMEOUT_CHARS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_strobe  (rx_strobe),
        .rx_error   (rx_error),
        .rd_en      (rd_en),
        .clr_status (clr_status),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .err_count  (err_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe a byte, present its error flag in the commit cycle; returns once visible.
    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_data   = b;
        rx_strobe = 1'b1;
        step();
        rx_strobe = 1'b0;
        rx_error  = err;
        step();
        rx_error  = 1'b0;
        $display("send byte 0x%02h err=%0b -> count=%0d", b, err, count);
    endtask

    task automatic pop_one();
        $display("pop 0x%03h", rd_data);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clear_status();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        $display("clr_status");
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_strobe  = 1'b0;
        rx_error   = 1'b0;
        rd_en      = 1'b0;
        clr_status = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_empty",    32'(empty),     32'd1);
        chk("rst_full",     32'(full),      32'd0);
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_errcnt",   32'(err_count), 32'd0);
        chk("rst_irq",      32'(irq),       32'd0);
        chk("rst_rd_data",  32'(rd_data),   32'd0);
        rst_n = 1'b1;
        repeat (6) step();

        // Single byte: 2-cycle write-to-visible latency
        rx_data   = 8'h5A;
        rx_strobe = 1'b1;
        step();
        rx_strobe = 1'b0;
        chk("t1_empty_in_commit", 32'(empty), 32'd1);
        step();
        $display("send byte 0x5a err=0 -> count=%0d", count);
        chk("t1_empty",   32'(empty),   32'd0);
        chk("t1_rd_data", 32'(rd_data), 32'h05A);
        chk("t1_count",   32'(count),   32'd1);
        pop_one();
        chk("t1_pop_empty", 32'(empty),   32'd1);
        chk("t1_pop_count", 32'(count),   32'd0);
        chk("t1_pop_rd",    32'(rd_data), 32'd0);

        // Errored byte, then clear
        send_byte(8'hC3, 1'b1);
        chk("t2_rd_data", 32'(rd_data),   32'h1C3);
        chk("t2_errcnt",  32'(err_count), 32'd1);
        pop_one();
        clear_status();
        chk("t2_clr_errcnt",   32'(err_count), 32'd0);
        chk("t2_clr_overflow", 32'(overflow),  32'd0);

        // Clear in the same cycle as an errored commit: event wins, counter = 1
        rx_data   = 8'hC4;
        rx_strobe = 1'b1;
        step();
        rx_strobe  = 1'b0;
        rx_error   = 1'b1;
        clr_status = 1'b1;
        step();
        rx_error   = 1'b0;
        clr_status = 1'b0;
        $display("send byte 0xc4 err=1 with clr_status");
        chk("t2b_errcnt",  32'(err_count), 32'd1);
        chk("t2b_rd_data", 32'(rd_data),   32'h1C4);
        pop_one();
        clear_status();
        chk("t2b_clr_errcnt", 32'(err_count), 32'd0);

        // Nine bytes into an 8-deep FIFO: last one dropped
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), 1'b0);
        end
        chk("t3_full",     32'(full),     32'd1);
        chk("t3_count",    32'(count),    32'd8);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_irq",      32'(irq),      32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_read", 32'(rd_data), 32'(i));
            pop_one();
        end
        chk("t3_drained", 32'(empty), 32'd1);
        clear_status();
        step();
        chk("t3_clr_overflow", 32'(overflow), 32'd0);
        chk("t3_irq_low",      32'(irq),      32'd0);

        // Full, commit with a simultaneous pop: no overflow, count stays 8
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(16 + i), 1'b0);
        end
        chk("t4_full", 32'(full), 32'd1);
        rx_data   = 8'hAA;
        rx_strobe = 1'b1;
        step();
        rx_strobe = 1'b0;
        rd_en     = 1'b1;
        step();
        rd_en     = 1'b0;
        $display("send byte 0xaa err=0 with pop on full -> count=%0d", count);
        chk("t4_count",    32'(count),    32'd8);
        chk("t4_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("t4_read", 32'(rd_data), 32'(16 + i));
            pop_one();
        end
        chk("t4_tail", 32'(rd_data), 32'h0AA);
        pop_one();
        chk("t4_drained", 32'(empty), 32'd1);

        // Strobe in the commit cycle must not be lost
        rx_data   = 8'h21;
        rx_strobe = 1'b1;
        step();
        rx_data   = 8'h22;
        step();
        rx_strobe = 1'b0;
        step();
        $display("back-to-back bytes 0x21 0x22 -> count=%0d", count);
        chk("t4b_count", 32'(count),   32'd2);
        chk("t4b_first", 32'(rd_data), 32'h021);
        pop_one();
        chk("t4b_second", 32'(rd_data), 32'h022);
        pop_one();

        // Idle timeout with three bytes below threshold
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        repeat (TMO_CYCLES - 1) step();
        chk("t5_irq_before", 32'(irq), 32'd0);
        step();
        chk("t5_irq_at_limit", 32'(irq), 32'd0);
        step();
        chk("t5_irq_timeout", 32'(irq), 32'd1);
        pop_one();
        step();
        chk("t5_irq_after_pop", 32'(irq),     32'd0);
        chk("t5_head",          32'(rd_data), 32'h032);

        // Async reset mid-stream with count = 5 and a capture in flight
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b0);
        chk("t6_count",  32'(count),     32'd5);
        chk("t6_errcnt", 32'(err_count), 32'd1);
        chk("t6_irq",    32'(irq),       32'd1);
        rx_data   = 8'h99;
        rx_strobe = 1'b1;
        step();
        rx_strobe = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        chk("t6_rst_count",    32'(count),     32'd0);
        chk("t6_rst_empty",    32'(empty),     32'd1);
        chk("t6_rst_full",     32'(full),      32'd0);
        chk("t6_rst_overflow", 32'(overflow),  32'd0);
        chk("t6_rst_errcnt",   32'(err_count), 32'd0);
        chk("t6_rst_irq",      32'(irq),       32'd0);
        chk("t6_rst_rd_data",  32'(rd_data),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_pending_dropped", 32'(empty), 32'd1);
        send_byte(8'h7E, 1'b0);
        chk("t6_after_rd",    32'(rd_data), 32'h07E);
        chk("t6_after_count", 32'(count),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
